imem_loader: RTL and testbench

- Boot-time programmer for the instruction memory.
- Accepts a framed byte stream (typically from a UART RX) and assembles little-endian 32-bit words.
- Drives the imem write port (write, addr_in, data) with consecutive word writes.
- Holds the CPU in reset until a complete, valid image has been written; then releases it.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/loader_timeout.sv | 42 ++++
 rtl/imem_loader.sv | 214 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loader_pkg                                              |
// | Description : Shared types and constants for the instruction-memory boot   |
// |               loader: FSM state encoding, byte/word widths, default sync   |
// |               marker.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int unsigned c_byte_w    = 8;
  localparam int unsigned c_word_w    = 32;
  localparam logic [7:0]  c_sync_byte = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : loader_timeout                                               |
// | Description : Inter-byte idle watchdog. Loadable down-counter: reloaded    |
// |               while not running or on a kick, otherwise counts down and    |
// |               raises o_expire once it reaches zero.                        |
// | Ports       : clk, rst_n   - clock, async active-low reset                 |
// |               i_run        - watchdog armed (inside a frame)               |
// |               i_kick       - byte accepted this cycle, restart the window  |
// |               o_expire     - idle window exhausted (combinational)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expire
);

  localparam int unsigned      c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || i_kick) begin
      r_cnt <= c_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A byte arriving on the last idle cycle still wins over the expiry.
  assign o_expire = i_run && !i_kick && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_loader                                                  |
// | Description : Boot-time instruction-memory programmer. Parses a framed     |
// |               byte stream (SYNC, N lo, N hi, 4*N data bytes LE[, XOR])     |
// |               into consecutive imem word writes and holds the CPU until a  |
// |               complete image is in place.                                  |
// | Ports       : clk, rst_n                 - clock, async active-low reset   |
// |               in_data/in_valid/in_ready  - byte stream handshake           |
// |               reload                     - pulse, restart load mode        |
// |               imem_write/addr/data       - imem write port                 |
// |               cpu_hold                   - CPU held while 1                |
// |               load_done, load_err        - status (load_err is sticky)     |
// | Options     : IMEM_LOADER_CHECKSUM_EN - trailing XOR checksum byte         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [7:0]  SYNC_BYTE      = c_sync_byte,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [c_byte_w-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                reload,
  output logic                imem_write,
  output logic [c_word_w-1:0] imem_addr,
  output logic [c_word_w-1:0] imem_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned c_idx_w = $clog2(DEPTH_WORDS) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t c_after_image = ST_CSUM;
`else
  localparam state_t c_after_image = ST_DONE;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_len;
  logic [c_idx_w-1:0]  r_idx;
  logic [1:0]          r_bsel;
  logic [23:0]         r_word;    // first three bytes of the word being built
  logic [c_word_w-1:0] r_addr;
  logic [c_word_w-1:0] r_data;
  logic                r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic        w_accept;
  logic        w_run;
  logic        w_expire;
  logic        w_sync;
  logic        w_oversize;
  logic        w_last_word;
  logic [15:0] w_len_full;

  assign w_accept    = in_valid && in_ready;
  assign w_sync      = (in_data == SYNC_BYTE);
  assign w_len_full  = {in_data, r_len[7:0]};
  assign w_oversize  = 32'(w_len_full) > DEPTH_WORDS;
  assign w_last_word = (32'(r_idx) + 32'd1) == 32'(r_len);

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .i_kick   (w_accept),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b1;
    imem_write   = 1'b0;
    cpu_hold     = 1'b1;
    load_done    = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_sync) w_next_state = ST_LEN0;
      end
      ST_LEN0: begin
        w_run = 1'b1;
        if (w_expire)      w_next_state = ST_IDLE;
        else if (w_accept) w_next_state = ST_LEN1;
      end
      ST_LEN1: begin
        w_run = 1'b1;
        if (w_expire) begin
          w_next_state = ST_IDLE;
        end else if (w_accept) begin
          if (w_len_full == 16'd0) w_next_state = c_after_image;
          else if (w_oversize)     w_next_state = ST_IDLE;
          else                     w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        w_run = 1'b1;
        if (w_expire)                         w_next_state = ST_IDLE;
        else if (w_accept && r_bsel == 2'd3)  w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        in_ready     = 1'b0;
        imem_write   = 1'b1;
        w_next_state = w_last_word ? c_after_image : ST_DATA;
      end
      ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_run = 1'b1;
        if (w_expire)      w_next_state = ST_IDLE;
        else if (w_accept) w_next_state = (in_data == r_csum) ? ST_DONE : ST_IDLE;
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (reload) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_bsel <= '0;
      r_word <= '0;
      r_addr <= BASE_ADDR;
      r_data <= '0;
      r_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else if (reload) begin
      // Reload wins over any byte or expiry this cycle; error flag is kept.
      r_idx <= '0;
    end else begin
      if (w_expire) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_sync) begin
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_bsel <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        end
        ST_LEN0: begin
          if (w_accept) r_len[7:0] <= in_data;
        end
        ST_LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= in_data;
            if (w_oversize) r_err <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_bsel <= r_bsel + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_data;
`endif
            case (r_bsel)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                // Capture the write now so the strobe cycle sees stable values.
                r_data <= {in_data, r_word};
                r_addr <= BASE_ADDR + (32'(r_idx) << 2);
              end
            endcase
          end
        end
        ST_WRITE: r_idx <= r_idx + 1'b1;
        ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_accept && in_data != r_csum) r_err <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_addr;
  assign imem_data = r_data;
  assign load_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                               |
// | Description : Self-checking bench for imem_loader: directed vector table,  |
// |               hand-written corner sequences and randomized frame streams   |
// |               checked against a frame-parsing reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int unsigned c_depth = 256;
  localparam logic [31:0] c_base  = 32'h0;
  localparam int unsigned c_tmo   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        imem_write;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH_WORDS    (c_depth),
    .BASE_ADDR      (c_base),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (c_tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_write (imem_write),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];
  bit          m_done;
  bit          m_err;

  always @(negedge clk) if (rst_n && imem_write) got_q.push_back({imem_addr, imem_data});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reload   = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
  endtask

  // Present a byte at a negedge and hold it until an edge with in_ready high.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   guard;
    guard    = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        total++;
        bad++;
        $display("FAIL send_byte: in_ready stuck low, got 0, expected 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int maxgap);
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_byte(stim[i]);
    end
  endtask

  function automatic logic [7:0] garbage();
    logic [7:0] g;
    g = 8'($urandom);
    if (g == 8'hA5) g = 8'h5A;
    return g;
  endfunction

  // Appends one frame with n random words; bad selects a wrong trailer.
  function automatic void add_frame(input int n, input bit bad_sum);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    stim.push_back(8'hA5);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x = x ^ b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(bad_sum ? ~x : x);
`else
    if (bad_sum) stim.push_back(x);
`endif
  endfunction

  // Reference: walk the byte list as a frame parser, from a freshly reset loader.
  function automatic void model();
    int         p;
    int         n;
    int         len;
    logic [31:0] w;
    logic [7:0]  x;
    p = 0;
    n = stim.size();
    exp_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    while (p < n && !m_done) begin
      if (stim[p] != 8'hA5) begin
        p++;
        continue;
      end
      p++;
      m_err = 1'b0;
      if (p + 2 > n) break;
      len = int'({stim[p+1], stim[p]});
      p += 2;
      if (len > int'(c_depth)) begin
        m_err = 1'b1;
        continue;
      end
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
        if (p + 4 > n) return;
        w = {stim[p+3], stim[p+2], stim[p+1], stim[p]};
        x = x ^ stim[p] ^ stim[p+1] ^ stim[p+2] ^ stim[p+3];
        exp_q.push_back({c_base + 32'(4 * k), w});
        p += 4;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (p >= n) break;
      if (stim[p] != x) begin
        m_err = 1'b1;
        p++;
        continue;
      end
      p++;
`endif
      m_done = 1'b1;
    end
  endfunction

  task automatic check_result(input string tag);
    repeat (4) @(negedge clk);
    check({tag, ".nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".wr"}, got_q[i], exp_q[i]);
    check({tag, ".done"}, 64'(load_done), 64'(m_done));
    check({tag, ".err"},  64'(load_err),  64'(m_err));
    check({tag, ".hold"}, 64'(cpu_hold),  64'(!m_done));
  endtask

  typedef struct {
    logic [7:0]  b [12];
    int          nb;
    bit          add_csum;
    logic [7:0]  csum;
    int          exp_nwr;
    logic [31:0] a0, d0, al, dl;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0].b = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF, 8'h00};
    vt[0].nb = 11; vt[0].add_csum = 1'b1; vt[0].csum = 8'h3C; vt[0].exp_nwr = 2;
    vt[0].a0 = 32'h0; vt[0].d0 = 32'h00100093; vt[0].al = 32'h4; vt[0].dl = 32'hFFDFF06F;
    vt[0].exp_done = 1'b1; vt[0].exp_err = 1'b0;

    vt[1].b = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1].nb = 10; vt[1].add_csum = 1'b1; vt[1].csum = 8'h13; vt[1].exp_nwr = 1;
    vt[1].a0 = 32'h0; vt[1].d0 = 32'h00000013; vt[1].al = 32'h0; vt[1].dl = 32'h00000013;
    vt[1].exp_done = 1'b1; vt[1].exp_err = 1'b0;

    vt[2].b = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].nb = 3; vt[2].add_csum = 1'b0; vt[2].csum = 8'h00; vt[2].exp_nwr = 0;
    vt[2].a0 = 32'h0; vt[2].d0 = 32'h0; vt[2].al = 32'h0; vt[2].dl = 32'h0;
    vt[2].exp_done = 1'b0; vt[2].exp_err = 1'b1;

    vt[3].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3].nb = 3; vt[3].add_csum = 1'b1; vt[3].csum = 8'h00; vt[3].exp_nwr = 0;
    vt[3].a0 = 32'h0; vt[3].d0 = 32'h0; vt[3].al = 32'h0; vt[3].dl = 32'h0;
    vt[3].exp_done = 1'b1; vt[3].exp_err = 1'b0;

    // Reset values while reset is held
    #3;
    check("rst.ready", 64'(in_ready),   64'd1);
    check("rst.write", 64'(imem_write), 64'd0);
    check("rst.addr",  64'(imem_addr),  64'(c_base));
    check("rst.data",  64'(imem_data),  64'd0);
    check("rst.hold",  64'(cpu_hold),   64'd1);
    check("rst.done",  64'(load_done),  64'd0);
    check("rst.err",   64'(load_err),   64'd0);

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < vt[v].nb; i++) send_byte(vt[v].b[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (vt[v].add_csum) send_byte(vt[v].csum);
`endif
      repeat (4) @(negedge clk);
      check("vec.nwr", 64'(got_q.size()), 64'(vt[v].exp_nwr));
      if (vt[v].exp_nwr > 0) begin
        check("vec.first", got_q[0], {vt[v].a0, vt[v].d0});
        check("vec.last",  got_q[got_q.size()-1], {vt[v].al, vt[v].dl});
      end
      check("vec.done", 64'(load_done), 64'(vt[v].exp_done));
      check("vec.err",  64'(load_err),  64'(vt[v].exp_err));
      check("vec.hold", 64'(cpu_hold),  64'(!vt[v].exp_done));
    end

    // Write strobe latency, idle gap shorter than the timeout, then reload from DONE
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (c_tmo - 5) @(negedge clk);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    check("lat.write", 64'(imem_write), 64'd1);
    check("lat.ready", 64'(in_ready),   64'd0);
    check("lat.word",  {imem_addr, imem_data}, {c_base, 32'h11223344});
    @(negedge clk);
    check("lat.wrlow", 64'(imem_write), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    repeat (2) @(negedge clk);
    check("gap.done", 64'(load_done), 64'd1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rld.hold", 64'(cpu_hold),  64'd1);
    check("rld.done", 64'(load_done), 64'd0);
    check("rld.err",  64'(load_err),  64'd0);
    got_q.delete();
    stim.delete();
    stim = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
    model();
    send_stream(0);
    check_result("rld.again");

    // Timeout inside DATA, then a clean frame recovers
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    repeat (3 * c_tmo) @(negedge clk);
    check("tmo.err",   64'(load_err),       64'd1);
    check("tmo.nwr",   64'(got_q.size()),   64'd0);
    check("tmo.hold",  64'(cpu_hold),       64'd1);
    send_byte(8'hA5);
    check("tmo.clear", 64'(load_err),       64'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h13);
`endif
    repeat (4) @(negedge clk);
    check("tmo.reload", got_q.size() > 0 ? got_q[got_q.size()-1] : 64'hX, {c_base, 32'h00000013});
    check("tmo.done",   64'(load_done), 64'd1);

    // Reload keeps load_err and beats a simultaneous sync byte
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    in_data = 8'hA5; in_valid = 1'b1; reload = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; reload = 1'b0;
    check("prio.err", 64'(load_err), 64'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (4) @(negedge clk);
    check("prio.nwr",  64'(got_q.size()), 64'd0);
    check("prio.hold", 64'(cpu_hold),     64'd1);

    // Asynchronous reset in the middle of the second word
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    #2 rst_n = 1'b0;
    #1;
    check("arst.data",  64'(imem_data),  64'd0);
    check("arst.addr",  64'(imem_addr),  64'(c_base));
    check("arst.write", 64'(imem_write), 64'd0);
    check("arst.ready", 64'(in_ready),   64'd1);
    check("arst.hold",  64'(cpu_hold),   64'd1);
    check("arst.done",  64'(load_done),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    stim = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h84};
    send_stream(0);
    repeat (4) @(negedge clk);
    check("csum.err",  64'(load_err), 64'd1);
    check("csum.hold", 64'(cpu_hold), 64'd1);
`endif

    // Largest image that fits
    do_reset();
    stim.delete();
    add_frame(int'(c_depth), 1'b0);
    model();
    send_stream(0);
    check_result("full");

    // Randomized streams: garbage, oversize headers, bad checksums, valid frames
    for (int it = 0; it < 20; it++) begin
      int kind;
      int n;
      do_reset();
      stim.delete();
      repeat ($urandom_range(0, 4)) stim.push_back(garbage());
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        n = $urandom_range(c_depth + 1, 400);
        stim.push_back(8'hA5);
        stim.push_back(n[7:0]);
        stim.push_back(n[15:8]);
      end else if (kind == 2) begin
        add_frame($urandom_range(1, 4), 1'b1);
      end
      add_frame($urandom_range(1, 5), 1'b0);
      repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom));
      model();
      send_stream(3);
      check_result("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
